// File: rtl/axis_sample_packer.sv
// Packs pairs of 32-bit ADC samples into 64-bit AXI-Stream words through a 2-entry output buffer.
// Latency: 1 cycle from the completing sample to m_axis_tvalid when the buffer is empty.
// Backpressure: input is never stalled; a word that finds the buffer full is dropped and counted.

// Generic shift-style FIFO; entry 0 is always the head, so the read port is a plain register.
module fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  ent     [DEPTH];
    logic [W-1:0]  ent_nxt [DEPTH];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] wr_idx;
    logic          push;
    logic          pop;

    assign pop    = rd_vld & rd_rdy;
    assign wr_rdy = (cnt != CW'(DEPTH)) | pop;
    assign push   = wr_vld & wr_rdy;
    assign rd_vld = (cnt != '0);
    assign rd_dat = ent[0];
    // A simultaneous pop shifts everything down one slot before the write lands.
    assign wr_idx = cnt - CW'(pop);

    always_comb begin
        ent_nxt = ent;
        cnt_nxt = cnt + CW'(push) - CW'(pop);
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_nxt[i] = ent[i + 1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    ent_nxt[i] = wr_dat;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            cnt <= '0;
        end else begin
            ent <= ent_nxt;
            cnt <= cnt_nxt;
        end
    end
endmodule

module axis_sample_packer #(
    parameter int S_TDATA_WIDTH = 32,
    parameter int M_TDATA_WIDTH = 64,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     cfg_enable,
    output logic [CNT_WIDTH-1:0]     sts_sample_count,
    output logic [15:0]              sts_drop_count,
    output logic                     sts_overflow,
    input  logic [S_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic [M_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready
);
    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_t;

    phase_t                   phase_q;
    phase_t                   phase_d;
    logic [S_TDATA_WIDTH-1:0] hold_q;
    logic [CNT_WIDTH-1:0]     sample_cnt_q;
    logic [15:0]              drop_cnt_q;
    logic                     overflow_q;
    logic                     accept;
    logic                     word_vld;
    logic                     word_rdy;
    logic                     drop;
    logic [M_TDATA_WIDTH-1:0] word_dat;

    assign accept   = s_axis_tvalid & cfg_enable;
    assign word_dat = {s_axis_tdata, hold_q};
    assign drop     = word_vld & ~word_rdy;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase_q <= PH_LO;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        word_vld = 1'b0;
        if (!cfg_enable) begin
            phase_d = PH_LO;
        end else if (s_axis_tvalid) begin
            case (phase_q)
                PH_LO: phase_d = PH_HI;
                PH_HI: begin
                    phase_d  = PH_LO;
                    word_vld = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hold_q <= '0;
        end else if (accept && phase_q == PH_LO) begin
            hold_q <= s_axis_tdata;
        end
    end

    // Disabling the run clears status so the controller sees fresh numbers on the next enable.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sample_cnt_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else if (!cfg_enable) begin
            sample_cnt_q <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (accept) begin
                sample_cnt_q <= sample_cnt_q + CNT_WIDTH'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_q <= drop_cnt_q + 16'd1;
                end
            end
        end
    end

    assign sts_sample_count = sample_cnt_q;
    assign sts_drop_count   = drop_cnt_q;
    assign sts_overflow     = overflow_q;

    fifo #(
        .W     (M_TDATA_WIDTH),
        .DEPTH (2)
    ) u_out_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_vld  (word_vld),
        .wr_dat  (word_dat),
        .wr_rdy  (word_rdy),
        .rd_vld  (m_axis_tvalid),
        .rd_dat  (m_axis_tdata),
        .rd_rdy  (m_axis_tready)
    );
endmodule

// File: doc/axis_sample_packer.md
# axis_sample_packer

Upstream feeder for the DDR RAM writer: accepts one 32-bit ADC sample word per beat (two 16-bit channels) from a source without backpressure and packs consecutive samples into 64-bit AXI-Stream words for the writer's FIFO. A 2-entry output buffer absorbs short stalls. When that buffer is full, completed words are dropped, counted and flagged rather than stalling the ADC path. Run control and status words are exposed for the acquisition controller.

## Interface
Parameters:
- S_TDATA_WIDTH, 32, input sample width. Fixed at 32.
- M_TDATA_WIDTH, 64, output word width. Must equal 2*S_TDATA_WIDTH.
- CNT_WIDTH, 32, width of the accepted-sample counter.

Ports:
- aclk  in  1  single clock for all logic.
- aresetn  in  1  reset, asynchronous, active-low.
- cfg_enable  in  1  run enable. Low: input ignored, packer and status cleared.
- sts_sample_count  out  CNT_WIDTH  samples accepted since enable rose. Wraps modulo 2^CNT_WIDTH.
- sts_drop_count  out  16  completed words dropped. Saturates at 16'hFFFF.
- sts_overflow  out  1  sticky. Set on first drop.
- s_axis_tdata  in  S_TDATA_WIDTH  sample: [15:0] ch A, [31:16] ch B.
- s_axis_tvalid  in  1  sample present. There is no tready; a valid sample is never back-pressured.
- m_axis_tdata  out  M_TDATA_WIDTH  packed word.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream accept.

## Operation
- Reset: m_axis_tvalid=0, m_axis_tdata=0, sts_sample_count=0, sts_drop_count=0, sts_overflow=0, phase=0, buffer empty.
- Accept condition: s_axis_tvalid & cfg_enable.
- Packing, phase 0: an accepted sample is stored in holding register bits [31:0]; phase becomes 1.
- Packing, phase 1: an accepted sample forms the word {sample, hold[31:0]}. The word is pushed to the output buffer and phase becomes 0.
- Earlier sample is always in the low half. Word layout is {B1,A1,B0,A0}.
- Output buffer is a 2-entry FIFO. The head is driven directly from registers onto m_axis_tdata/m_axis_tvalid.
- Pop: m_axis_tvalid & m_axis_tready.
- Push allowed when occupancy < 2, or when a pop occurs in the same cycle.
- Push not allowed: the word is discarded, sts_drop_count increments (saturating) and sts_overflow is set.
- Transmitted words are never corrupted.
- cfg_enable low:
  - phase forced to 0 and any partial word discarded;
  - sts_sample_count, sts_drop_count and sts_overflow are cleared;
  - the buffer keeps draining and already-buffered words are still delivered.
- cfg_enable rising: the first accepted sample starts at phase 0.
- sts_sample_count increments by 1 on every accepted sample, including one that completes a dropped word.
- AXIS rule: once m_axis_tvalid is asserted, m_axis_tdata stays stable and tvalid stays high until the pop.

## Timing
- Latency: the sample completing a word at edge N gives m_axis_tvalid=1 with that word after edge N, provided the buffer was empty. Latency is 1 cycle.
- Sustained input: with tvalid=1 every cycle, one word is produced every 2 cycles. Steady state therefore tolerates m_axis_tready duty cycles of 50% or more with no drops.
- Buffer full, push and pop in the same cycle: the push succeeds and occupancy stays 2.
- Head popped at edge N: the second entry appears on m_axis_tdata after edge N, with no bubble.
- Status outputs are registered and update on the edge following the event.
- Wrap: sts_sample_count at all-ones goes to 0 on the next accepted sample.
- Saturation: sts_drop_count at 16'hFFFF holds.
- Asynchronous reset mid-burst clears everything immediately. Buffered words are lost and m_axis_tvalid drops without waiting for tready.

## Test plan
- Basic pack: enable=1, tready=1, samples 0x00010000, 0x00030002 -> one beat m_axis_tdata=0x0003000200010000, one cycle after the 2nd sample; sts_sample_count=2.
- Odd flush: enable=1, send 3 samples, drop enable, raise enable, send 0xAAAA5555, 0xCCCC3333 -> words 1 and 2 only, then 0xCCCC3333AAAA5555; no stale half-word; counters restart at 0.
- Backpressure/drop: tready=0, 8 continuous samples (4 words) -> exactly 2 buffered, sts_drop_count=2, sts_overflow=1. Raise tready -> the first two words emerge in order.
- Full with simultaneous pop: hold buffer full, assert tready for exactly the cycle a new word completes -> no drop; occupancy 2; sequence intact.
- Reset mid-operation: assert aresetn=0 with 2 words buffered and phase=1 -> m_axis_tvalid=0 and all status 0 immediately. After release, 2 samples yield exactly one correct word.
- Counter boundaries: force-preload sts_sample_count to 2^CNT_WIDTH-1 and accept 1 sample -> 0. Cause 65536 drops -> sts_drop_count=16'hFFFF, held.
